// File: rtl/mul_div_unit.sv
// mul_div_unit: HI/LO multiply/divide unit with fixed-latency MULT/DIV and MTHI/MTLO moves
module mul_div_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    localparam logic [4:0] MC = 5'(MULT_CYCLES - 1);
    localparam logic [4:0] DC = 5'(DIV_CYCLES - 1);
    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic               sgn, an, bn;
    logic [WIDTH-1:0]   ma, mb, mbs, uq, ur, quo, rem;
    assign busy = state_q == RUN;
    assign done = state_q == FINISH;
    assign hi   = hi_q;
    assign lo   = lo_q;
    // Result datapath: product over the low 2*WIDTH bits of extended operands, division on magnitudes then re-signed
    always_comb begin
        sgn   = ~op_q[0];
        a_ext = {{WIDTH{sgn & a_q[WIDTH-1]}}, a_q};
        b_ext = {{WIDTH{sgn & b_q[WIDTH-1]}}, b_q};
        prod  = a_ext * b_ext;
        an    = sgn & a_q[WIDTH-1];
        bn    = sgn & b_q[WIDTH-1];
        ma    = an ? -a_q : a_q;
        mb    = bn ? -b_q : b_q;
        mbs   = (mb == '0) ? WIDTH'(1) : mb;
        uq    = ma / mbs;
        ur    = ma % mbs;
        quo   = (an ^ bn) ? -uq : uq;
        rem   = an ? -ur : ur;
    end
    // Next-state: accept ops whenever not running (including the done cycle), count down, write HI/LO at completion
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state_q == RUN) begin
            if (cnt_q == '0) begin
                state_d = FINISH;
                if (!op_q[1]) begin
                    {hi_d, lo_d} = prod;
                end else if (b_q != '0) begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end else begin
                cnt_d = cnt_q - 5'd1;
            end
        end else begin
            state_d = IDLE;
            if (start && !op[2]) begin
                state_d = RUN;
                cnt_d   = op[1] ? DC : MC;
                op_d    = op[1:0];
                a_d     = a;
                b_d     = b;
            end else if (start && op == 3'd4) begin
                hi_d = a;
            end else if (start && op == 3'd5) begin
                lo_d = a;
            end
        end
    end
    // State register with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule
